// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared RAM constants, mem_master state encoding and address wrap helper
package mem_pkg;

  localparam int MEM_WIDTH      = 16;
  localparam int MEM_DEPTH      = 128;
  localparam int MEM_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_RESP
  } mm_state_t;

  // Wraps explicitly at depth-1 so non-power-of-2 RAMs never see an out-of-range address
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_master_stats.sv
// rtl/mem_master_stats.sv - saturating write/read beat counters for mem_master
module mem_master_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_inc,
  input  logic        rd_inc,
  output logic [15:0] wr_beats,
  output logic [15:0] rd_beats
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_beats <= 16'd0;
      rd_beats <= 16'd0;
    end else begin
      if (wr_inc && (wr_beats != 16'hFFFF)) wr_beats <= wr_beats + 16'd1;
      if (rd_inc && (rd_beats != 16'hFFFF)) rd_beats <= rd_beats + 16'd1;
    end
  end

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - burst read/write initiator for the single-port RAM
// Define MEM_MASTER_STATS_EN to add the wr_beats/rd_beats counter outputs.
module mem_master
  import mem_pkg::*;
#(
  parameter int          WIDTH      = MEM_WIDTH,
  parameter int unsigned DEPTH      = MEM_DEPTH,
  parameter int          ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int          LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [WIDTH-1:0]      wd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_last,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_w_data,
  output logic                  mem_w_en,
  output logic                  mem_r_en,
  input  logic [WIDTH-1:0]      mem_r_data
`ifdef MEM_MASTER_STATS_EN
  ,
  output logic [15:0]           wr_beats,
  output logic [15:0]           rd_beats
`endif
);

  mm_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_nxt, addr_inc;
  logic [LEN_WIDTH-1:0]  beats_left, left_nxt;
  logic                  done_nxt, err_nxt;

  assign addr_inc = ADDR_WIDTH'(next_addr(32'(cur_addr), DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= addr_nxt;
      beats_left <= left_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  // Every output is forced low while rst is high, whatever state the burst was in
  always_comb begin
    state_nxt  = state;
    addr_nxt   = cur_addr;
    left_nxt   = beats_left;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    req_ready  = 1'b0;
    wd_ready   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    mem_w_en   = 1'b0;
    mem_r_en   = 1'b0;
    if (!rst) begin
      mem_addr = cur_addr;
      case (state)
        IDLE: begin
          // Hold off new commands during the done pulse cycle
          req_ready = !done;
          if (req_valid && !done) begin
            if (32'(req_addr) >= DEPTH) begin
              err_nxt = 1'b1;
            end else begin
              addr_nxt  = req_addr;
              left_nxt  = req_len;
              state_nxt = req_write ? WRITE : RD_ISSUE;
            end
          end
        end
        WRITE: begin
          wd_ready   = 1'b1;
          mem_w_en   = wd_valid;
          mem_w_data = wd_data;
          if (wd_valid) begin
            if (beats_left == '0) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              addr_nxt = addr_inc;
              left_nxt = beats_left - LEN_WIDTH'(1);
            end
          end
        end
        RD_ISSUE: begin
          mem_r_en  = 1'b1;
          state_nxt = RD_RESP;
        end
        RD_RESP: begin
          rsp_valid = 1'b1;
          rsp_data  = mem_r_data;
          rsp_last  = (beats_left == '0);
          if (rsp_ready) begin
            if (beats_left == '0) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              addr_nxt  = addr_inc;
              left_nxt  = beats_left - LEN_WIDTH'(1);
              state_nxt = RD_ISSUE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef MEM_MASTER_STATS_EN
  mem_master_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .wr_inc   (wd_valid && wd_ready),
    .rd_inc   (rsp_valid && rsp_ready),
    .wr_beats (wr_beats),
    .rd_beats (rd_beats)
  );
`endif

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed self-checking bench for mem_master with a RAM model
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [6:0]  req_addr;
  logic [3:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [15:0] wd_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [15:0] rsp_data;
  logic        done, err;
  logic [6:0]  mem_addr;
  logic [15:0] mem_w_data, mem_r_data;
  logic        mem_w_en, mem_r_en;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [6:0]  b_req_addr;
  logic [3:0]  b_req_len;
  logic        b_wd_ready, b_rsp_valid, b_rsp_ready, b_rsp_last, b_done, b_err;
  logic [15:0] b_rsp_data, b_mem_w_data;
  logic [6:0]  b_mem_addr;
  logic        b_mem_w_en, b_mem_r_en;
  logic        b_wd_valid = 1'b0;
  logic [15:0] b_wd_data = 16'h0;
  logic [15:0] b_mem_r_data = 16'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
    .mem_r_en(mem_r_en), .mem_r_data(mem_r_data)
  );

  mem_master #(.DEPTH(100)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_len(b_req_len),
    .wd_valid(b_wd_valid), .wd_ready(b_wd_ready), .wd_data(b_wd_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
    .done(b_done), .err(b_err),
    .mem_addr(b_mem_addr), .mem_w_data(b_mem_w_data), .mem_w_en(b_mem_w_en),
    .mem_r_en(b_mem_r_en), .mem_r_data(b_mem_r_data)
  );

  // Single-port RAM model: registered read data holds while r_en is low
  logic [15:0] ram [0:127];
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= ram[mem_addr];
  end

  logic [6:0]  wa_q[$];
  logic [15:0] wdat_q[$];
  int rcnt = 0, done_cnt = 0, rst_acc = 0;
  always @(negedge clk) begin
    if (mem_w_en) begin
      wa_q.push_back(mem_addr);
      wdat_q.push_back(mem_w_data);
    end
    if (mem_r_en) rcnt++;
    if (done) done_cnt++;
    if (rst && (mem_w_en || mem_r_en || b_mem_w_en || b_mem_r_en)) rst_acc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] wbuf [16];
  logic [15:0] ebuf [16];
  logic        gap  [16];

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) gap[i] = 1'b0;
  endtask

  task automatic start_cmd(input logic wr, input int a, input int l);
    logic acc;
    acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = 7'(a); req_len = 4'(l);
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic write_burst(input int a, input int l);
    int base;
    start_cmd(1'b1, a, l);
    base = wa_q.size();
    for (int i = 0; i <= l; i++) begin
      if (gap[i]) begin
        wd_valid = 1'b0;
        @(posedge clk); #1;
      end
      wd_valid = 1'b1; wd_data = wbuf[i];
      @(negedge clk);
      check("wd_ready", 32'(wd_ready), 32'd1);
      @(posedge clk); #1;
    end
    wd_valid = 1'b0;
    check("wr_count", 32'(wa_q.size() - base), 32'(l + 1));
    for (int i = 0; i <= l && base + i < wa_q.size(); i++) begin
      check("wr_addr", 32'(wa_q[base + i]), 32'((a + i) % 128));
      check("wr_data", 32'(wdat_q[base + i]), 32'(wbuf[i]));
    end
    @(negedge clk);
    check("wr_done", 32'(done), 32'd1);
    check("wr_done_no_req", 32'(req_ready), 32'd0);
  endtask

  task automatic read_burst(input int a, input int l);
    int got, first_t;
    start_cmd(1'b0, a, l);
    @(negedge clk);
    check("rd_issue", {30'd0, rsp_valid, mem_r_en}, 32'd1);
    check("rd_issue_addr", 32'(mem_addr), 32'(a));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    got = 0; first_t = -1;
    for (int t = 0; t < 100 && got <= l; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (first_t < 0) first_t = t;
        check("rd_data", 32'(rsp_data), 32'(ebuf[got]));
        check("rd_last", 32'(rsp_last), 32'(got == l));
        got++;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    check("rd_beats", 32'(got), 32'(l + 1));
    check("rd_first_latency", 32'(first_t), 32'd0);
    @(negedge clk);
    check("rd_done", 32'(done), 32'd1);
    check("rd_done_no_req", 32'(req_ready), 32'd0);
  endtask

  int r0, d0, base, bad;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_len = '0; b_rsp_ready = 1'b0;
    clear_gaps();

    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_en", {30'd0, mem_w_en, mem_r_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_flags", {28'd0, done, err, rsp_valid, wd_ready}, 32'd0);
    check("post_rst_addr", 32'(mem_addr), 32'd0);

    // single write then read
    wbuf[0] = 16'hA5A5;
    write_burst(5, 0);
    ebuf[0] = 16'hA5A5;
    read_burst(5, 0);

    // wrap burst across the top of the RAM
    wbuf[0] = 16'd1; wbuf[1] = 16'd2; wbuf[2] = 16'd3; wbuf[3] = 16'd4;
    write_burst(126, 3);
    check("ram_wrap0", 32'(ram[0]), 32'd3);
    check("ram_wrap127", 32'(ram[127]), 32'd2);
    ebuf[0] = 16'd1; ebuf[1] = 16'd2; ebuf[2] = 16'd3; ebuf[3] = 16'd4;
    read_burst(126, 3);

    // backpressure on a 2-beat read of RAM[126..127]
    start_cmd(1'b0, 126, 1);
    r0 = rcnt;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 16'd1 || mem_r_en) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_single_issue", 32'(rcnt - r0), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_beat0", {15'd0, rsp_last, rsp_data}, 32'h0000_0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_issue2", {24'd0, mem_r_en, mem_addr}, {24'd0, 1'b1, 7'd127});
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_beat1", {15'd0, rsp_last, rsp_data}, 32'h0001_0002);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_done", 32'(done), 32'd1);

    // write with wd_valid gaps
    clear_gaps();
    gap[0] = 1'b1; gap[1] = 1'b1; gap[2] = 1'b1;
    wbuf[0] = 16'h0011; wbuf[1] = 16'h0022; wbuf[2] = 16'h0033;
    write_burst(20, 2);
    clear_gaps();
    ebuf[0] = 16'h0011; ebuf[1] = 16'h0022; ebuf[2] = 16'h0033;
    read_burst(20, 2);

    // reset in the middle of a long read
    start_cmd(1'b0, 0, 7);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    check("in_rst_outputs", {27'd0, rsp_valid, req_ready, mem_r_en, mem_w_en, wd_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd10; req_len = 4'd0;
    @(negedge clk);
    check("after_rst_state", {29'd0, rsp_valid, done, req_ready}, 32'd1);
    check("after_rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; wd_valid = 1'b1; wd_data = 16'h1234;
    base = wa_q.size();
    @(negedge clk);
    check("after_rst_write", {24'd0, mem_w_en, mem_addr}, {24'd0, 1'b1, 7'd10});
    @(posedge clk); #1;
    wd_valid = 1'b0;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);
    check("after_rst_done", 32'(done), 32'd1);

    // rejection on the DEPTH=100 instance, then a wrapping read at 99
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 7'd100; b_req_len = 4'd0;
    @(negedge clk);
    check("rej_req_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check("rej_err", 32'(b_err), 32'd1);
    check("rej_no_access", {29'd0, b_mem_w_en, b_mem_r_en, b_wd_ready}, 32'd0);
    check("rej_idle", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rej_err_pulse", 32'(b_err), 32'd0);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 7'd99; b_req_len = 4'd1; b_rsp_ready = 1'b1;
    @(negedge clk);
    check("b_accept", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_issue99", {23'd0, b_err, b_mem_r_en, b_mem_addr}, {23'd0, 1'b0, 1'b1, 7'd99});
    @(posedge clk); #1;
    @(negedge clk);
    check("b_rsp", 32'(b_rsp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_wrap_issue", {24'd0, b_mem_r_en, b_mem_addr}, {24'd0, 1'b1, 7'd0});
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;

    check("no_access_in_rst", 32'(rst_acc), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
